// File: rtl/inst_fetch.sv
// ---------------------------------------------------------------------------
// inst_fetch : PC holder and req/ack instruction fetch FSM with retry
// Revision   : 1.0 initial release
// ---------------------------------------------------------------------------
`default_nettype none

module inst_fetch #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          MAX_WAIT = 8
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  input  logic        stall,
  input  logic        Branch,
  input  logic        Jump,
  input  logic        Zero,
  output logic [31:0] pc,
  output logic [31:0] inst,
  output logic [5:0]  OP,
  output logic        inst_valid,
  output logic        fetch_err
);

  localparam int            CW         = $clog2(MAX_WAIT + 1);
  localparam logic [CW-1:0] c_max_wait = CW'(MAX_WAIT);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FETCH = 2'd1,
    ST_RETRY = 2'd2,
    ST_EXEC  = 2'd3
  } state_t;

  state_t        r_state, w_state_nxt;
  logic [31:0]   r_pc, w_pc_nxt;
  logic [31:0]   r_inst, w_inst_nxt;
  logic [CW-1:0] r_cnt, w_cnt_nxt, w_cnt_inc;
  logic          r_err, w_err_nxt;

  logic [31:0]   w_pc4, w_jump_tgt, w_br_tgt, w_br_off;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= ST_IDLE;
      r_pc    <= RESET_PC;
      r_inst  <= '0;
      r_cnt   <= '0;
      r_err   <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_pc    <= w_pc_nxt;
      r_inst  <= w_inst_nxt;
      r_cnt   <= w_cnt_nxt;
      r_err   <= w_err_nxt;
    end
  end

  assign w_pc4      = r_pc + 32'd4;
  assign w_jump_tgt = {w_pc4[31:28], r_inst[25:0], 2'b00};
  assign w_br_off   = {{14{r_inst[15]}}, r_inst[15:0], 2'b00};
  assign w_br_tgt   = w_pc4 + w_br_off;
  assign w_cnt_inc  = r_cnt + 1'b1;

  always_comb begin
    w_state_nxt = r_state;
    w_pc_nxt    = r_pc;
    w_inst_nxt  = r_inst;
    w_cnt_nxt   = r_cnt;
    w_err_nxt   = r_err;
    case (r_state)
      ST_IDLE:  w_state_nxt = ST_FETCH;
      ST_FETCH: begin
        if (imem_ack) begin
          w_inst_nxt  = imem_rdata;
          w_cnt_nxt   = '0;
          w_state_nxt = ST_EXEC;
        end else if (w_cnt_inc == c_max_wait) begin
          w_err_nxt   = 1'b1;
          w_cnt_nxt   = '0;
          w_state_nxt = ST_RETRY;
        end else begin
          w_cnt_nxt   = w_cnt_inc;
        end
      end
      ST_RETRY: w_state_nxt = ST_FETCH;
      ST_EXEC: begin
        if (!stall) begin
          // Jump outranks a taken branch.
          if (Jump)                w_pc_nxt = w_jump_tgt;
          else if (Branch && Zero) w_pc_nxt = w_br_tgt;
          else                     w_pc_nxt = w_pc4;
          w_state_nxt = ST_FETCH;
        end
      end
      default:  w_state_nxt = ST_IDLE;
    endcase
  end

  assign imem_req   = (r_state == ST_FETCH);
  assign imem_addr  = r_pc;
  assign pc         = r_pc;
  assign inst       = r_inst;
  assign OP         = r_inst[31:26];
  assign inst_valid = (r_state == ST_EXEC);
  assign fetch_err  = r_err;

endmodule

`default_nettype wire

// File: tb/tb_inst_fetch.sv
// ---------------------------------------------------------------------------
// tb_inst_fetch : directed scenarios plus randomized fetch stream vs. model
// Revision      : 1.0 initial release
// ---------------------------------------------------------------------------
`default_nettype none

module tb_inst_fetch;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        ack = 1'b0, stall = 1'b0, br = 1'b0, jmp = 1'b0, zero = 1'b0;
  logic [31:0] rdata = '0;
  logic        m_req, m_valid, m_err;
  logic [31:0] m_addr, m_pc, m_inst;
  logic [5:0]  m_op;

  logic        w_ack = 1'b0;
  logic [31:0] w_rdata = '0;
  logic        w_zero_in = 1'b0;
  logic        w_req, w_valid, w_err;
  logic [31:0] w_addr, w_pc, w_inst;
  logic [5:0]  w_op;

  int errors = 0;
  int checks = 0;

  inst_fetch #(.RESET_PC(32'h0000_0000), .MAX_WAIT(4)) u_main (
    .clk(clk), .rst(rst), .imem_req(m_req), .imem_addr(m_addr),
    .imem_ack(ack), .imem_rdata(rdata), .stall(stall),
    .Branch(br), .Jump(jmp), .Zero(zero),
    .pc(m_pc), .inst(m_inst), .OP(m_op), .inst_valid(m_valid), .fetch_err(m_err)
  );

  inst_fetch #(.RESET_PC(32'hFFFF_FFFC), .MAX_WAIT(8)) u_wrap (
    .clk(clk), .rst(rst), .imem_req(w_req), .imem_addr(w_addr),
    .imem_ack(w_ack), .imem_rdata(w_rdata), .stall(w_zero_in),
    .Branch(w_zero_in), .Jump(w_zero_in), .Zero(w_zero_in),
    .pc(w_pc), .inst(w_inst), .OP(w_op), .inst_valid(w_valid), .fetch_err(w_err)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Next PC from the architectural rules, in plain arithmetic.
  function automatic logic [31:0] ref_next(input logic [31:0] p, input logic [31:0] ins,
                                           input logic b, input logic j, input logic z);
    logic [31:0] p4;
    logic [15:0] imm;
    p4  = p + 32'd4;
    imm = ins[15:0];
    if (j)          return (p4 & 32'hF000_0000) | ((ins & 32'h03FF_FFFF) << 2);
    else if (b && z) return p4 + 32'($signed(imm) * 4);
    return p4;
  endfunction

  task automatic wait_req(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 12; i++) begin
      if (m_req) begin ok = 1'b1; return; end
      step();
    end
  endtask

  task automatic test_reset();
    repeat (2) step();
    checks++; if (m_pc !== 32'h0) begin errors++; $display("FAIL reset_pc: got %h want %h", m_pc, 32'h0); end
    checks++; if (m_inst !== 32'h0 || m_op !== 6'h0) begin errors++; $display("FAIL reset_inst: got %h/%h want 0/0", m_inst, m_op); end
    checks++; if ({m_req, m_valid, m_err} !== 3'b000) begin errors++; $display("FAIL reset_flags: got %b want 000", {m_req, m_valid, m_err}); end
    checks++; if (w_pc !== 32'hFFFF_FFFC) begin errors++; $display("FAIL reset_pc_wrap: got %h want fffffffc", w_pc); end
  endtask

  task automatic test_startup_branch();
    rst = 1'b1;
    checks++; if (m_req !== 1'b0) begin errors++; $display("FAIL idle_req: got %b want 0", m_req); end
    step();
    checks++; if (m_req !== 1'b1 || m_addr !== 32'h0) begin errors++; $display("FAIL first_req: got %b@%h want 1@0", m_req, m_addr); end
    checks++; if (w_req !== 1'b1 || w_addr !== 32'hFFFF_FFFC) begin errors++; $display("FAIL first_req_wrap: got %b@%h want 1@fffffffc", w_req, w_addr); end
    ack = 1'b1; rdata = 32'h1000_0003; br = 1'b1; zero = 1'b1; jmp = 1'b0;
    w_ack = 1'b1; w_rdata = 32'h0000_0020;
    step();
    ack = 1'b0; w_ack = 1'b0;
    checks++; if (m_valid !== 1'b1 || m_op !== 6'b000100 || m_inst !== 32'h1000_0003) begin errors++; $display("FAIL startup_exec: got v=%b op=%b inst=%h want v=1 op=000100 inst=10000003", m_valid, m_op, m_inst); end
    checks++; if (m_req !== 1'b0 || m_pc !== 32'h0) begin errors++; $display("FAIL startup_exec_pc: got req=%b pc=%h want 0/0", m_req, m_pc); end
    checks++; if (w_valid !== 1'b1 || w_op !== 6'h0) begin errors++; $display("FAIL wrap_exec: got v=%b op=%h want 1/0", w_valid, w_op); end
    step();
    checks++; if (m_req !== 1'b1 || m_addr !== 32'h10) begin errors++; $display("FAIL branch_taken: got %b@%h want 1@10", m_req, m_addr); end
    checks++; if (w_req !== 1'b1 || w_addr !== 32'h0) begin errors++; $display("FAIL wrap_next: got %b@%h want 1@0", w_req, w_addr); end
  endtask

  task automatic test_jump();
    ack = 1'b1; rdata = 32'h0800_0040; jmp = 1'b1; br = 1'b1; zero = 1'b1;
    step();
    ack = 1'b0;
    checks++; if (m_op !== 6'b000010 || m_pc !== 32'h10 || m_valid !== 1'b1) begin errors++; $display("FAIL jump_exec: got op=%b pc=%h v=%b want 000010/10/1", m_op, m_pc, m_valid); end
    step();
    jmp = 1'b0;
    checks++; if (m_req !== 1'b1 || m_addr !== 32'h100) begin errors++; $display("FAIL jump_target: got %b@%h want 1@100", m_req, m_addr); end
  endtask

  task automatic test_neg_branch_stall();
    int vcnt;
    ack = 1'b1; rdata = 32'h1000_FFFF; br = 1'b1; zero = 1'b1; jmp = 1'b0; stall = 1'b1;
    step();
    ack = 1'b0;
    vcnt = 0;
    for (int i = 0; i < 4; i++) begin
      if (m_valid === 1'b1 && m_pc === 32'h100 && m_inst === 32'h1000_FFFF) vcnt++;
      stall = (i < 3);
      jmp   = (i < 3);
      step();
    end
    jmp = 1'b0;
    checks++; if (vcnt !== 4) begin errors++; $display("FAIL stall_hold: got %0d held cycles want 4", vcnt); end
    checks++; if (m_valid !== 1'b0 || m_req !== 1'b1 || m_addr !== 32'h100) begin errors++; $display("FAIL neg_branch: got v=%b req=%b addr=%h want 0/1/100", m_valid, m_req, m_addr); end
  endtask

  task automatic test_timeout_retry();
    int c;
    checks++; if (m_err !== 1'b0) begin errors++; $display("FAIL err_pre: got %b want 0", m_err); end
    ack = 1'b0;
    c = 0;
    while (m_req === 1'b1 && c < 20) begin
      c++;
      step();
    end
    checks++; if (c !== 4) begin errors++; $display("FAIL timeout_len: got %0d req cycles want 4", c); end
    checks++; if (m_err !== 1'b1 || m_req !== 1'b0 || m_pc !== 32'h100) begin errors++; $display("FAIL retry_state: got err=%b req=%b pc=%h want 1/0/100", m_err, m_req, m_pc); end
    step();
    checks++; if (m_req !== 1'b1 || m_addr !== 32'h100) begin errors++; $display("FAIL retry_refetch: got %b@%h want 1@100", m_req, m_addr); end
    ack = 1'b1; rdata = 32'h0000_0020; br = 1'b0; jmp = 1'b0; zero = 1'b0; stall = 1'b0;
    step();
    ack = 1'b0;
    checks++; if (m_valid !== 1'b1 || m_err !== 1'b1) begin errors++; $display("FAIL retry_exec: got v=%b err=%b want 1/1", m_valid, m_err); end
    step();
    checks++; if (m_req !== 1'b1 || m_addr !== 32'h104) begin errors++; $display("FAIL after_retry: got %b@%h want 1@104", m_req, m_addr); end
  endtask

  task automatic test_reset_midfetch();
    step();
    #2 rst = 1'b0;
    #1;
    checks++; if (m_req !== 1'b0 || m_pc !== 32'h0 || m_err !== 1'b0) begin errors++; $display("FAIL async_reset: got req=%b pc=%h err=%b want 0/0/0", m_req, m_pc, m_err); end
    ack = 1'b1; rdata = 32'hDEAD_BEEF;
    repeat (2) step();
    checks++; if (m_inst !== 32'h0 || m_valid !== 1'b0 || m_req !== 1'b0) begin errors++; $display("FAIL ack_in_reset: got inst=%h v=%b req=%b want 0/0/0", m_inst, m_valid, m_req); end
    ack = 1'b0;
    rst = 1'b1;
    step();
    checks++; if (m_req !== 1'b1 || m_addr !== 32'h0) begin errors++; $display("FAIL restart: got %b@%h want 1@0", m_req, m_addr); end
  endtask

  task automatic test_random();
    logic [31:0] mpc, ins;
    logic        b, j, z;
    int          d, s;
    bit          ok;
    mpc = 32'h0;
    for (int n = 0; n < 60; n++) begin
      wait_req(ok);
      checks++; if (!ok) begin errors++; $display("FAIL rnd_req_timeout: got no req want req within 12 cycles"); break; end
      d = $urandom_range(0, 3);
      for (int k = 0; k < d; k++) begin
        ack = 1'b0;
        step();
        checks++; if (m_req !== 1'b1 || m_addr !== mpc) begin errors++; $display("FAIL rnd_wait: got %b@%h want 1@%h", m_req, m_addr, mpc); end
      end
      ins = $urandom;
      ack = 1'b1; rdata = ins;
      s = $urandom_range(0, 2);
      stall = (s > 0);
      step();
      for (int k = 0; k <= s; k++) begin
        checks++;
        if (m_valid !== 1'b1 || m_inst !== ins || m_op !== ins[31:26] || m_pc !== mpc) begin
          errors++;
          $display("FAIL rnd_exec: got v=%b inst=%h op=%h pc=%h want 1/%h/%h/%h", m_valid, m_inst, m_op, m_pc, ins, ins[31:26], mpc);
        end
        if (k < s) begin
          stall = 1'b1; ack = 1'($urandom); rdata = $urandom;
          br = 1'($urandom); jmp = 1'($urandom); zero = 1'($urandom);
        end else begin
          stall = 1'b0; ack = 1'b0;
          b = 1'($urandom); j = ($urandom_range(0, 3) == 0); z = 1'($urandom);
          br = b; jmp = j; zero = z;
        end
        step();
      end
      mpc = ref_next(mpc, ins, b, j, z);
    end
    checks++; if (m_err !== 1'b0) begin errors++; $display("FAIL rnd_err: got %b want 0", m_err); end
  endtask

  initial begin
    test_reset();
    test_startup_branch();
    test_jump();
    test_neg_branch_stall();
    test_timeout_retry();
    test_reset_midfetch();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/inst_fetch.md
Name: inst_fetch

Overview:
- Instruction-fetch front end for the single-cycle CPU; it is the producer side of the opcode/control interface.
- Holds the PC and runs a req/ack handshake with instruction memory.
- Presents each fetched instruction and its OP field to the control decoder, then takes Branch/Jump back from the decoder and Zero from the ALU to select the next PC.
- Tolerates variable-latency instruction memory, pipeline stall, and memory timeout with retry.

Parameters:
- RESET_PC, 32'h0000_0000, PC loaded on reset; must be word aligned.
- MAX_WAIT, 8, FETCH cycles without ack before timeout and retry (must be >= 1).

Ports:
- clk  in  1  system clock; all state updates on rising edge.
- rst  in  1  asynchronous, active-low reset.
- imem_req  out  1  fetch request to instruction memory.
- imem_addr  out  32  fetch address; equals pc.
- imem_ack  in  1  memory accepts the request and imem_rdata is valid this cycle.
- imem_rdata  in  32  instruction word.
- stall  in  1  hold the current instruction in EXEC.
- Branch  in  1  from control decoder.
- Jump  in  1  from control decoder.
- Zero  in  1  from ALU.
- pc  out  32  address of the current instruction.
- inst  out  32  current instruction register.
- OP  out  6  inst[31:26], to control decoder.
- inst_valid  out  1  inst/OP are valid for execution.
- fetch_err  out  1  sticky flag: at least one timeout occurred.

Behaviour:
- Reset (rst low, asynchronous, any state):
  - pc=RESET_PC, inst=0, OP=0, imem_req=0, inst_valid=0, fetch_err=0, wait counter=0, state=IDLE.
  - Reset during FETCH drops imem_req immediately. An ack arriving while rst is low is ignored.
- FSM states: IDLE, FETCH, RETRY, EXEC.
  - IDLE: outputs at reset values. Always moves to FETCH next cycle, so the first imem_req is in the 2nd cycle after rst deasserts.
  - FETCH: imem_req=1. imem_addr=pc, stable while req is high.
    - imem_ack=1 at a clock edge: inst<=imem_rdata, counter<=0, go to EXEC.
    - Otherwise counter increments. If the count reaches MAX_WAIT with no ack: fetch_err<=1, counter<=0, go to RETRY.
  - RETRY: imem_req=0 for exactly one cycle, pc unchanged, then FETCH (same address).
  - EXEC: inst_valid=1, imem_req=0.
    - stall=1: remain in EXEC; inst, pc, OP unchanged.
    - stall=0: update pc per next-PC rules, go to FETCH.
- Throughput and ack rules:
  - Minimum 2 cycles per instruction (same-cycle ack).
  - imem_ack outside FETCH is ignored; no state change.
- Next-PC rules, evaluated in the EXEC cycle with stall=0:
  - pc4 = pc+4, modulo 2^32.
  - Jump=1: {pc4[31:28], inst[25:0], 2'b00}. Jump has priority over Branch.
  - Branch=1 and Zero=1: pc4 + (sign-extended inst[15:0] << 2), 32-bit modulo.
  - Otherwise: pc4.
  - Branch, Jump, and Zero are ignored in every other state and while stall=1.
- OP is always inst[31:26], purely combinational from the register.
- fetch_err clears only on reset.

Test Plan:
- Reset/startup: RESET_PC=0, rst released; mem acks at once with 0x1000_0003, Branch=1, Zero=1 -> imem_req first high in 2nd cycle, addr 0x0; OP=6'b000100 with inst_valid=1; next fetch addr 0x10.
- Jump: at pc 0x10 fetch 0x0800_0040, Jump=1, Branch=1, Zero=1 -> next addr 0x100 (Jump wins); OP=6'b000010.
- Negative branch and stall: at pc 0x100, inst 0x1000_FFFF, Branch=1, Zero=1, stall high 3 cycles -> inst_valid high 4 cycles, pc held at 0x100; next addr 0x100.
- Wrap and not-taken: RESET_PC=32'hFFFF_FFFC, inst 0x0000_0020 (R-type), Branch=0, Jump=0 -> next addr 0x0000_0000.
- Timeout/retry: MAX_WAIT=4, no ack -> req high 4 cycles, fetch_err=1, req low 1 cycle, req high again at the same addr; ack then arrives -> EXEC, fetch_err stays 1.
- Reset mid-fetch: rst pulled low while req high and before ack, ack asserted during reset -> req drops asynchronously, inst stays 0; after release, restart from RESET_PC.
